// File: rtl/fetch_pkg.sv
// Shared fetch constants and FSM state type.
// Used by the fetch sequencer, ROM and decoder.
package fetch_pkg;

  localparam int          ADDR_W     = 8;
  localparam int          INST_W     = 10;
  localparam int          CNT_W      = 16;
  localparam int unsigned START_ADDR = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC / next-state mux for the fetch sequencer.
// Purely combinational; all state lives in the parent.
module fetch_next_pc #(
  parameter int          ADDR_W     = 8,
  parameter int unsigned START_ADDR = 1
) (
  input  fetch_pkg::state_e  i_state,
  input  logic [ADDR_W-1:0]  i_pc,
  input  logic               i_start,
  input  logic               i_stall,
  input  logic               i_valid,
  input  logic               i_halt,
  input  logic               i_br,
  input  logic [ADDR_W-1:0]  i_br_tgt,
  output fetch_pkg::state_e  o_state,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_clear,
  output logic               o_load,
  output logic               o_kill,
  output logic               o_retire
);
  import fetch_pkg::*;

  logic w_adv;
  logic w_hlt;
  logic w_jmp;

  assign w_adv = (i_state == RUN) & ~i_stall;
  // Halt outranks a same-cycle branch.
  assign w_hlt = w_adv & i_valid & i_halt;
  assign w_jmp = w_adv & i_valid & i_br & ~i_halt;

  always_comb begin
    o_state  = i_state;
    o_pc     = i_pc;
    o_clear  = 1'b0;
    o_load   = 1'b0;
    o_kill   = 1'b0;
    o_retire = w_adv & i_valid;
    unique case (i_state)
      IDLE, DONE: begin
        if (i_start) begin
          o_state = RUN;
          o_pc    = ADDR_W'(START_ADDR);
          o_clear = 1'b1;
        end
      end
      RUN: begin
        unique case (1'b1)
          w_hlt: begin
            o_state = DONE;
            o_kill  = 1'b1;
          end
          w_jmp: begin
            o_pc   = i_br_tgt;
            o_kill = 1'b1;
          end
          default: begin
            if (w_adv) begin
              o_load = 1'b1;
              o_pc   = i_pc + 1'b1;
            end
          end
        endcase
      end
      default: o_state = IDLE;
    endcase
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the ROM address and
// registers each fetched word for the decoder.
module inst_fetch_ctrl #(
  parameter int          ADDR_W     = fetch_pkg::ADDR_W,
  parameter int          INST_W     = fetch_pkg::INST_W,
  parameter int unsigned START_ADDR = fetch_pkg::START_ADDR,
  parameter int          CNT_W      = fetch_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  inst_count
);
  import fetch_pkg::*;

  state_e            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_inst_pc;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt;

  state_e            w_state;
  logic [ADDR_W-1:0] w_pc;
  logic              w_clear;
  logic              w_load;
  logic              w_kill;
  logic              w_retire;

  fetch_next_pc #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR)
  ) u_next (
    .i_state  (r_state),
    .i_pc     (r_pc),
    .i_start  (start),
    .i_stall  (stall),
    .i_valid  (r_valid),
    .i_halt   (halt),
    .i_br     (branch_taken),
    .i_br_tgt (branch_target),
    .o_state  (w_state),
    .o_pc     (w_pc),
    .o_clear  (w_clear),
    .o_load   (w_load),
    .o_kill   (w_kill),
    .o_retire (w_retire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pc      <= ADDR_W'(START_ADDR);
      r_inst    <= '0;
      r_inst_pc <= '0;
      r_valid   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      if (w_load) begin
        r_inst    <= rom_data;
        r_inst_pc <= r_pc;
      end
      if (w_clear | w_kill) begin
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_valid <= 1'b1;
      end
      // Counter saturates rather than wrapping.
      if (w_clear) begin
        r_cnt <= '0;
      end else if (w_retire && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign rom_addr   = r_pc;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_valid = r_valid;
  assign inst_count = r_cnt;
  assign busy       = (r_state == RUN);
  assign done       = (r_state == DONE);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios
// plus randomized traffic against a cycle-level behavioural model.
module tb_inst_fetch_ctrl;

  localparam int AW   = 8;
  localparam int IW   = 10;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_data;
  logic [IW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_valid;
  logic          stall;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          halt;
  logic          busy;
  logic          done;
  logic [CW-1:0] inst_count;

  logic [IW-1:0] rom [256];
  assign rom_data = rom[rom_addr];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: mode 0=idle 1=run 2=done
  int mdl_mode;
  int mdl_pc;
  int mdl_inst;
  int mdl_ipc;
  int mdl_valid;
  int mdl_cnt;

  inst_fetch_ctrl #(.CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .busy          (busy),
    .done          (done),
    .inst_count    (inst_count)
  );

  always #5 clk = ~clk;

  task automatic bump();
    if (mdl_cnt < CMAX) mdl_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      mdl_mode = 0; mdl_pc = 1; mdl_inst = 0;
      mdl_ipc = 0; mdl_valid = 0; mdl_cnt = 0;
    end else if (mdl_mode != 1) begin
      if (start) begin
        mdl_mode = 1; mdl_pc = 1; mdl_valid = 0; mdl_cnt = 0;
      end
    end else if (!stall) begin
      if (mdl_valid == 1 && halt) begin
        mdl_mode = 2; mdl_valid = 0; bump();
      end else if (mdl_valid == 1 && branch_taken) begin
        mdl_pc = int'(branch_target); mdl_valid = 0; bump();
      end else begin
        if (mdl_valid == 1) bump();
        mdl_inst  = int'(rom[mdl_pc]);
        mdl_ipc   = mdl_pc;
        mdl_valid = 1;
        mdl_pc    = (mdl_pc + 1) % 256;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; stall = 0; branch_taken = 0;
    halt = 0; branch_target = '0;
  endtask

  task automatic run_to(input int k);
    for (int i = 0; i < 300 && !(inst_valid && int'(inst_pc) == k); i++)
      tick();
    n_checks++;
    if (!(inst_valid && int'(inst_pc) == k)) begin
      n_fail++;
      $display("FAIL run_to: inst_pc=%0h want %0h (timeout)", inst_pc, k);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    n_checks++;
    if ({rom_addr, inst, inst_pc, inst_valid, busy, done, inst_count}
        !== {8'd1, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL reset: addr=%0h inst=%0h ipc=%0h v=%b b=%b d=%b c=%0d",
               rom_addr, inst, inst_pc, inst_valid, busy, done, inst_count);
    end
  endtask

  task automatic test_start();
    start = 1;
    tick();
    start = 0;
    n_checks++;
    if (busy !== 1'b1 || inst_valid !== 1'b0 || rom_addr !== 8'd1) begin
      n_fail++;
      $display("FAIL start_run: busy=%b v=%b addr=%0h want 1 0 1",
               busy, inst_valid, rom_addr);
    end
    tick();
    n_checks++;
    if (inst !== 10'h080 || inst_pc !== 8'd1 || inst_valid !== 1'b1 ||
        inst_count !== 5'd0) begin
      n_fail++;
      $display("FAIL first_fetch: inst=%0h ipc=%0h v=%b c=%0d want 80 1 1 0",
               inst, inst_pc, inst_valid, inst_count);
    end
    tick();
    n_checks++;
    if (inst !== 10'h212 || inst_pc !== 8'd2 || inst_count !== 5'd1) begin
      n_fail++;
      $display("FAIL second_fetch: inst=%0h ipc=%0h c=%0d want 212 2 1",
               inst, inst_pc, inst_count);
    end
    tick();
    n_checks++;
    if (inst_pc !== 8'd3 || inst_count !== 5'd2) begin
      n_fail++;
      $display("FAIL third_fetch: ipc=%0h c=%0d want 3 2", inst_pc, inst_count);
    end
  endtask

  task automatic test_stall();
    logic [IW-1:0] held;
    run_to(5);
    held = inst;
    stall = 1; halt = 1; branch_taken = 1; branch_target = 8'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (inst !== held || inst_pc !== 8'd5 || inst_count !== 5'd4 ||
          inst_valid !== 1'b1 || busy !== 1'b1 || rom_addr !== 8'd6) begin
        n_fail++;
        $display("FAIL stall_hold: inst=%0h ipc=%0h c=%0d v=%b want %0h 5 4 1",
                 inst, inst_pc, inst_count, inst_valid, held);
      end
    end
    idle_inputs();
    tick();
    n_checks++;
    if (inst_pc !== 8'd6 || inst_count !== 5'd5 || inst !== rom[6]) begin
      n_fail++;
      $display("FAIL stall_release: ipc=%0h c=%0d want 6 5", inst_pc, inst_count);
    end
  endtask

  task automatic test_branch();
    run_to(9);
    branch_taken = 1; branch_target = 8'h14;
    tick();
    idle_inputs();
    n_checks++;
    if (inst_valid !== 1'b0 || inst_count !== 5'd9 || rom_addr !== 8'h14) begin
      n_fail++;
      $display("FAIL branch_bubble: v=%b c=%0d addr=%0h want 0 9 14",
               inst_valid, inst_count, rom_addr);
    end
    tick();
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 8'h14 || inst !== rom[8'h14] ||
        inst_count !== 5'd9) begin
      n_fail++;
      $display("FAIL branch_target: v=%b ipc=%0h c=%0d want 1 14 9",
               inst_valid, inst_pc, inst_count);
    end
    tick();
    n_checks++;
    if (inst_pc !== 8'h15 || inst_count !== 5'd10) begin
      n_fail++;
      $display("FAIL branch_after: ipc=%0h c=%0d want 15 10", inst_pc, inst_count);
    end
  endtask

  task automatic test_halt();
    reset = 1; tick(); reset = 0;
    start = 1; tick(); start = 0;
    run_to(10);
    start = 1;
    tick();
    start = 0;
    n_checks++;
    if (inst_pc !== 8'd11 || inst_count !== 5'd10 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_run: ipc=%0h c=%0d want b 10", inst_pc, inst_count);
    end
    run_to(27);
    halt = 1; branch_taken = 1; branch_target = 8'h33;
    tick();
    idle_inputs();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || inst_valid !== 1'b0 ||
        rom_addr !== 8'd28 || inst_count !== 5'd27) begin
      n_fail++;
      $display("FAIL halt: d=%b b=%b v=%b addr=%0h c=%0d want 1 0 0 1c 27",
               done, busy, inst_valid, rom_addr, inst_count);
    end
    tick(); tick();
    n_checks++;
    if (done !== 1'b1 || inst_count !== 5'd27 || rom_addr !== 8'd28) begin
      n_fail++;
      $display("FAIL done_hold: d=%b c=%0d addr=%0h want 1 27 1c",
               done, inst_count, rom_addr);
    end
    start = 1;
    tick();
    start = 0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || rom_addr !== 8'd1 ||
        inst_count !== 5'd0) begin
      n_fail++;
      $display("FAIL restart: b=%b d=%b addr=%0h c=%0d want 1 0 1 0",
               busy, done, rom_addr, inst_count);
    end
    tick();
    n_checks++;
    if (inst_pc !== 8'd1 || inst !== 10'h080 || inst_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_fetch: ipc=%0h inst=%0h want 1 80", inst_pc, inst);
    end
  endtask

  task automatic test_wrap();
    branch_taken = 1; branch_target = 8'hFF;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (inst_pc !== 8'hFF || inst_valid !== 1'b1 || rom_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_ff: ipc=%0h v=%b addr=%0h want ff 1 0",
               inst_pc, inst_valid, rom_addr);
    end
    tick();
    n_checks++;
    if (inst_pc !== 8'h00 || inst !== rom[0] || inst_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_00: ipc=%0h v=%b want 0 1", inst_pc, inst_valid);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1;
    tick();
    reset = 0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || inst_valid !== 1'b0 ||
        rom_addr !== 8'd1 || inst_count !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_mid: b=%b d=%b v=%b addr=%0h c=%0d want 0 0 0 1 0",
               busy, done, inst_valid, rom_addr, inst_count);
    end
  endtask

  task automatic test_saturate();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 45; i++) tick();
    n_checks++;
    if (inst_count !== 5'(CMAX) || inst_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate: c=%0d want %0d", inst_count, CMAX);
    end
    reset = 1; tick(); reset = 0;
  endtask

  task automatic test_random();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 99) < 1);
      start         = ($urandom_range(0, 99) < 6);
      stall         = ($urandom_range(0, 99) < 30);
      halt          = ($urandom_range(0, 99) < 4);
      branch_taken  = ($urandom_range(0, 99) < 15);
      branch_target = AW'($urandom);
      tick();
      n_checks++;
      if ({rom_addr, inst, inst_pc, inst_valid, busy, done, inst_count} !==
          {AW'(mdl_pc), IW'(mdl_inst), AW'(mdl_ipc), mdl_valid == 1,
           mdl_mode == 1, mdl_mode == 2, CW'(mdl_cnt)}) begin
        n_fail++;
        $display("FAIL random[%0d]: addr=%0h inst=%0h ipc=%0h v=%b b=%b d=%b c=%0d want %0h %0h %0h %0d m%0d %0d",
                 i, rom_addr, inst, inst_pc, inst_valid, busy, done,
                 inst_count, mdl_pc, mdl_inst, mdl_ipc, mdl_valid,
                 mdl_mode, mdl_cnt);
      end
    end
    idle_inputs();
    reset = 0;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = IW'($urandom);
    rom[1] = 10'h080;
    rom[2] = 10'h212;
    mdl_mode = 0; mdl_pc = 1; mdl_inst = 0;
    mdl_ipc = 0; mdl_valid = 0; mdl_cnt = 0;
    reset = 0;
    idle_inputs();
    test_reset();
    test_start();
    test_stall();
    test_branch();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
